// File: rtl/mips32_pipe_fwd.sv
// mips32_pipe_fwd: single-clock 5-stage MIPS32 core with bypass, interlock, branch flush and retire counter
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   imem_addr / imem_data       fetch port (address = PC, data same cycle)
//   dmem_addr / dmem_wdata      MEM-stage address and store data (0 when MEM is a bubble)
//   dmem_we / dmem_rdata        store strobe, load data same cycle
//   dbg_raddr / dbg_rdata       combinational register peek
//   halted, instret             sticky halt flag, retired-instruction count
module mips32_pipe_fwd #(
    parameter int XLEN    = 32,
    parameter int PC_W    = 10,
    parameter int DA_W    = 10,
    parameter int FORWARD = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_data,
    output logic [DA_W-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic             dmem_we,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic [4:0]       dbg_raddr,
    output logic [XLEN-1:0]  dbg_rdata,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;

    logic [XLEN-1:0] rf [32];
    logic [PC_W-1:0] pc, pc_inc, ifid_npc, idex_npc, br_tgt;
    logic            fetch_stop, ifid_v, idex_v, exmem_v, memwb_v;
    logic [31:0]     ifid_ir, idex_ir;
    logic [XLEN-1:0] idex_a, idex_b, exmem_alu, exmem_b, memwb_res;
    logic            idex_wr, idex_lw, idex_sw, idex_br, idex_hlt;
    logic            exmem_wr, exmem_lw, exmem_sw, exmem_hlt, memwb_wr, memwb_hlt;
    logic [4:0]      idex_dst, exmem_dst, memwb_dst;

    logic [5:0]      id_op, ex_op;
    logic [4:0]      id_rs, id_rt, id_dst, ex_rs, ex_rt;
    logic            id_rr, id_ia, id_lw, id_sw, id_br, id_hlt, id_wr, id_use_rt;
    logic [XLEN-1:0] id_a, id_b, fa, fb, opb, alu;
    logic            wb_we, hit_ex, hit_mem, stall, taken, stop, frz;
    logic            fx_a, fw_a, fx_b, fw_b;

    assign pc_inc    = pc + PC_W'(1);
    assign imem_addr = pc;
    assign dbg_rdata = rf[dbg_raddr];

    assign id_op     = ifid_ir[31:26];
    assign id_rs     = ifid_ir[25:21];
    assign id_rt     = ifid_ir[20:16];
    assign id_rr     = id_op <= OP_MUL;
    assign id_ia     = id_op == OP_ADDI || id_op == OP_SUBI || id_op == OP_SLTI;
    assign id_lw     = id_op == OP_LW;
    assign id_sw     = id_op == OP_SW;
    assign id_br     = id_op == OP_BNEQZ || id_op == OP_BEQZ;
    // every unassigned opcode behaves as HLT
    assign id_hlt    = !(id_rr || id_ia || id_lw || id_sw || id_br);
    assign id_wr     = id_rr || id_ia || id_lw;
    assign id_dst    = id_rr ? ifid_ir[15:11] : id_rt;
    assign id_use_rt = id_rr || id_sw;

    // write-first register file: the WB write is visible to ID in the same cycle
    assign wb_we = memwb_v && memwb_wr && memwb_dst != 5'd0;
    assign id_a  = wb_we && memwb_dst == id_rs ? memwb_res : rf[id_rs];
    assign id_b  = wb_we && memwb_dst == id_rt ? memwb_res : rf[id_rt];

    assign hit_ex  = idex_dst != 5'd0 && ((!id_hlt && idex_dst == id_rs) || (id_use_rt && idex_dst == id_rt));
    assign hit_mem = exmem_dst != 5'd0 && ((!id_hlt && exmem_dst == id_rs) || (id_use_rt && exmem_dst == id_rt));
    // with bypass only a load feeding the next instruction stalls; without it any in-flight producer does
    assign stall = ifid_v && (FORWARD != 0 ? idex_v && idex_lw && hit_ex
                                           : (idex_v && idex_wr && hit_ex) || (exmem_v && exmem_wr && hit_mem));

    assign ex_op = idex_ir[31:26];
    assign ex_rs = idex_ir[25:21];
    assign ex_rt = idex_ir[20:16];
    assign fx_a  = FORWARD != 0 && exmem_v && exmem_wr && exmem_dst != 5'd0 && exmem_dst == ex_rs;
    assign fw_a  = FORWARD != 0 && wb_we && memwb_dst == ex_rs;
    assign fx_b  = FORWARD != 0 && exmem_v && exmem_wr && exmem_dst != 5'd0 && exmem_dst == ex_rt;
    assign fw_b  = FORWARD != 0 && wb_we && memwb_dst == ex_rt;
    assign fa    = fx_a ? exmem_alu : fw_a ? memwb_res : idex_a;
    assign fb    = fx_b ? exmem_alu : fw_b ? memwb_res : idex_b;
    assign opb   = ex_op <= OP_MUL ? fb : XLEN'($signed(idex_ir[15:0]));
    assign alu   = (ex_op == OP_SUB || ex_op == OP_SUBI) ? fa - opb :
                   ex_op == OP_AND ? fa & opb :
                   ex_op == OP_OR  ? fa | opb :
                   (ex_op == OP_SLT || ex_op == OP_SLTI) ? XLEN'(fa < opb) :
                   ex_op == OP_MUL ? fa * opb : fa + opb;

    assign taken  = idex_v && idex_br && (ex_op == OP_BEQZ ? fa == '0 : fa != '0);
    assign br_tgt = idex_npc + PC_W'($signed(idex_ir[15:0]));
    // a HLT in ID blocks fetch at once unless an older branch is flushing it
    assign stop   = fetch_stop || (ifid_v && id_hlt && !taken);
    assign frz    = halted || (memwb_v && memwb_hlt);

    assign dmem_we    = exmem_v && exmem_sw;
    assign dmem_addr  = exmem_v ? DA_W'(exmem_alu) : '0;
    assign dmem_wdata = exmem_v ? exmem_b : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= '0;
            fetch_stop <= 1'b0;
            halted     <= 1'b0;
            instret    <= '0;
            ifid_v     <= 1'b0;
            idex_v     <= 1'b0;
            exmem_v    <= 1'b0;
            memwb_v    <= 1'b0;
            ifid_ir    <= '0;
            ifid_npc   <= '0;
            idex_ir    <= '0;
            idex_npc   <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_wr    <= 1'b0;
            idex_lw    <= 1'b0;
            idex_sw    <= 1'b0;
            idex_br    <= 1'b0;
            idex_hlt   <= 1'b0;
            idex_dst   <= '0;
            exmem_alu  <= '0;
            exmem_b    <= '0;
            exmem_wr   <= 1'b0;
            exmem_lw   <= 1'b0;
            exmem_sw   <= 1'b0;
            exmem_hlt  <= 1'b0;
            exmem_dst  <= '0;
            memwb_res  <= '0;
            memwb_wr   <= 1'b0;
            memwb_hlt  <= 1'b0;
            memwb_dst  <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (memwb_v && !halted) instret <= instret + CNT_W'(1);
            if (memwb_v && memwb_hlt) halted <= 1'b1;
            if (!frz) begin
                fetch_stop <= stop;
                if (taken) begin
                    pc     <= br_tgt;
                    ifid_v <= 1'b0;
                end else if (!stall) begin
                    if (stop) begin
                        ifid_v <= 1'b0;
                    end else begin
                        pc       <= pc_inc;
                        ifid_v   <= 1'b1;
                        ifid_ir  <= imem_data;
                        ifid_npc <= pc_inc;
                    end
                end
                idex_v    <= ifid_v && !taken && !stall;
                idex_ir   <= ifid_ir;
                idex_npc  <= ifid_npc;
                idex_a    <= id_a;
                idex_b    <= id_b;
                idex_wr   <= id_wr;
                idex_lw   <= id_lw;
                idex_sw   <= id_sw;
                idex_br   <= id_br;
                idex_hlt  <= id_hlt;
                idex_dst  <= id_dst;
                exmem_v   <= idex_v;
                exmem_alu <= alu;
                exmem_b   <= fb;
                exmem_wr  <= idex_wr;
                exmem_lw  <= idex_lw;
                exmem_sw  <= idex_sw;
                exmem_hlt <= idex_hlt;
                exmem_dst <= idex_dst;
                memwb_v   <= exmem_v;
                memwb_res <= exmem_lw ? dmem_rdata : exmem_alu;
                memwb_wr  <= exmem_wr;
                memwb_hlt <= exmem_hlt;
                memwb_dst <= exmem_dst;
                if (wb_we) rf[memwb_dst] <= memwb_res;
            end
        end
    end
endmodule

// File: tb/tb_mips32_pipe_fwd.sv
// tb_mips32_pipe_fwd: directed programs run on a bypassing and a non-bypassing core with store/register scoreboards
module tb_mips32_pipe_fwd;
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
    localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, BNEQZ = 6'b001101, BEQZ = 6'b001110;
    localparam logic [31:0] HLT = 32'hFC00_0000;

    typedef struct packed { logic [4:0] r; logic [31:0] v; } rexp_t;
    typedef struct packed { logic [9:0] a; logic [31:0] d; } sexp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  dbg_raddr = '0;
    logic [9:0]  ia1, ia0, da1, da0;
    logic [31:0] id1, id0, wd1, wd0, rd1, rd0, dr1, dr0, instret1, instret0;
    logic        we1, we0, halt1, halt0;
    logic [31:0] imem [1024];
    logic [31:0] dm1 [1024];
    logic [31:0] dm0 [1024];
    int          checks = 0, failures = 0, hc1, hc0;
    rexp_t       rq[$];
    sexp_t       sq1[$], sq0[$];

    always #5 clk = ~clk;

    assign id1 = imem[ia1];
    assign id0 = imem[ia0];
    assign rd1 = dm1[da1];
    assign rd0 = dm0[da0];

    always @(posedge clk) begin
        if (we1) dm1[da1] <= wd1;
        if (we0) dm0[da0] <= wd0;
    end

    mips32_pipe_fwd #(.FORWARD(1)) d1 (
        .clk(clk), .rst_n(rst_n), .imem_addr(ia1), .imem_data(id1), .dmem_addr(da1), .dmem_wdata(wd1),
        .dmem_we(we1), .dmem_rdata(rd1), .dbg_raddr(dbg_raddr), .dbg_rdata(dr1), .halted(halt1), .instret(instret1)
    );

    mips32_pipe_fwd #(.FORWARD(0)) d0 (
        .clk(clk), .rst_n(rst_n), .imem_addr(ia0), .imem_data(id0), .dmem_addr(da0), .dmem_wdata(wd0),
        .dmem_we(we0), .dmem_rdata(rd0), .dbg_raddr(dbg_raddr), .dbg_rdata(dr0), .halted(halt0), .instret(instret0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [5:0] op, input int rs, input int rt, input int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    always @(negedge clk) begin : mon1
        sexp_t s;
        if (rst_n && we1) begin
            chk("store_f1_expected", sq1.size() != 0, 1);
            if (sq1.size() != 0) begin
                s = sq1.pop_front();
                chk("store_f1_addr", da1, s.a);
                chk("store_f1_data", wd1, s.d);
            end
        end
    end

    always @(negedge clk) begin : mon0
        sexp_t s;
        if (rst_n && we0) begin
            chk("store_f0_expected", sq0.size() != 0, 1);
            if (sq0.size() != 0) begin
                s = sq0.pop_front();
                chk("store_f0_addr", da0, s.a);
                chk("store_f0_data", wd0, s.d);
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) begin
            imem[i] = 32'hFFFF_FFFF;
            dm1[i] = '0;
            dm0[i] = '0;
        end
        rq.delete();
        sq1.delete();
        sq0.delete();
    endtask

    task automatic push_reg(input int r, input logic [31:0] v);
        rq.push_back('{r: 5'(r), v: v});
    endtask

    task automatic push_st(input int a, input logic [31:0] d);
        sq1.push_back('{a: 10'(a), d: d});
        sq0.push_back('{a: 10'(a), d: d});
    endtask

    task automatic check_idle(input string name);
        chk($sformatf("%s_pc_f1", name), ia1, 0);
        chk($sformatf("%s_pc_f0", name), ia0, 0);
        chk($sformatf("%s_we_f1", name), we1, 0);
        chk($sformatf("%s_we_f0", name), we0, 0);
        chk($sformatf("%s_halted_f1", name), halt1, 0);
        chk($sformatf("%s_halted_f0", name), halt0, 0);
        chk($sformatf("%s_instret_f1", name), instret1, 0);
        chk($sformatf("%s_instret_f0", name), instret0, 0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_idle(name);
    endtask

    task automatic run(input string name, input int budget);
        hc1 = -1;
        hc0 = -1;
        for (int c = 0; c < budget && (hc1 < 0 || hc0 < 0); c++) begin
            if (halt1 && hc1 < 0) hc1 = c;
            if (halt0 && hc0 < 0) hc0 = c;
            @(negedge clk);
        end
        chk($sformatf("%s_halt_in_budget_f1", name), hc1 >= 0, 1);
        chk($sformatf("%s_halt_in_budget_f0", name), hc0 >= 0, 1);
    endtask

    task automatic finish_prog(input string name, input int ninst);
        rexp_t e;
        repeat (3) @(negedge clk);
        chk($sformatf("%s_halted_f1", name), halt1, 1);
        chk($sformatf("%s_halted_f0", name), halt0, 1);
        chk($sformatf("%s_instret_f1", name), instret1, ninst);
        chk($sformatf("%s_instret_f0", name), instret0, ninst);
        chk($sformatf("%s_stores_left_f1", name), sq1.size(), 0);
        chk($sformatf("%s_stores_left_f0", name), sq0.size(), 0);
        while (rq.size() != 0) begin
            e = rq.pop_front();
            dbg_raddr = e.r;
            #1;
            chk($sformatf("%s_r%0d_f1", name, e.r), dr1, e.v);
            chk($sformatf("%s_r%0d_f0", name, e.r), dr0, e.v);
        end
    endtask

    task automatic load_loop();
        clear_prog();
        imem[0] = ri(ADDI, 0, 1, 5);
        imem[1] = ri(ADDI, 0, 2, 1);
        imem[2] = rr(MUL, 2, 1, 2);
        imem[3] = ri(SUBI, 1, 1, 1);
        imem[4] = ri(BNEQZ, 1, 0, -3);
        imem[5] = HLT;
        push_reg(2, 120);
        push_reg(1, 0);
    endtask

    initial begin
        clear_prog();
        imem[0] = ri(ADDI, 0, 1, 10);
        imem[1] = ri(ADDI, 0, 2, 20);
        imem[2] = rr(ADD, 1, 2, 3);
        imem[3] = rr(SUB, 3, 1, 4);
        imem[4] = HLT;
        push_reg(1, 10);
        push_reg(2, 20);
        push_reg(3, 30);
        push_reg(4, 20);
        do_reset("raw_reset");
        run("raw", 200);
        chk("raw_halt_cycle_f1", hc1, 9);
        chk("raw_f0_halts_later", hc0 > hc1, 1);
        finish_prog("raw", 5);

        clear_prog();
        imem[0] = ri(ADDI, 0, 1, 7);
        imem[1] = ri(SW, 0, 1, 100);
        imem[2] = ri(LW, 0, 4, 100);
        imem[3] = rr(ADD, 4, 4, 5);
        imem[4] = HLT;
        push_st(100, 7);
        push_reg(4, 7);
        push_reg(5, 14);
        do_reset("ldu_reset");
        run("ldu", 200);
        chk("ldu_halt_cycle_f1", hc1, 10);
        finish_prog("ldu", 5);

        clear_prog();
        imem[0] = ri(BEQZ, 0, 0, 2);
        imem[1] = ri(ADDI, 0, 6, 1);
        imem[2] = ri(ADDI, 0, 7, 1);
        imem[3] = ri(ADDI, 0, 8, 5);
        imem[4] = HLT;
        push_reg(6, 0);
        push_reg(7, 0);
        push_reg(8, 5);
        do_reset("br_reset");
        run("br", 200);
        chk("br_halt_cycle_f1", hc1, 9);
        finish_prog("br", 3);

        clear_prog();
        imem[0] = ri(ADDI, 0, 1, 1);
        imem[1] = ri(BNEQZ, 1, 0, 1);
        imem[2] = HLT;
        imem[3] = ri(ADDI, 0, 9, 3);
        imem[4] = HLT;
        push_reg(1, 1);
        push_reg(9, 3);
        do_reset("wp_reset");
        run("wp", 200);
        chk("wp_halt_cycle_f1", hc1, 10);
        finish_prog("wp", 4);

        load_loop();
        do_reset("loop_reset");
        run("loop", 400);
        finish_prog("loop", 18);

        load_loop();
        do_reset("mid_reset");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("mid_pulse");
        dbg_raddr = 5'd1;
        #1;
        chk("mid_r1_cleared_f1", dr1, 0);
        chk("mid_r1_cleared_f0", dr0, 0);
        dbg_raddr = 5'd2;
        #1;
        chk("mid_r2_cleared_f1", dr1, 0);
        chk("mid_r2_cleared_f0", dr0, 0);
        run("mid", 400);
        finish_prog("mid", 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips32_pipe_fwd.md
Name: mips32_pipe_fwd

Overview:
- Parametrised single-clock successor to the team's two-phase 5-stage MIPS32 core. Same ISA and encodings.
- Adds external instruction/data memory ports, forwarding, hazard interlock, branch flush, valid bits per stage and a retired-instruction counter.
- Sits as the CPU core between the instruction ROM and the data RAM in the SoC top.

Parameters:
- XLEN, 32, datapath/register width (≥16); immediates are sign-extended from bit 15 to XLEN.
- PC_W, 10, instruction address width (word-addressed).
- DA_W, 10, data address width (word-addressed); the low DA_W bits of the effective address are used.
- FORWARD, 1, 1 = EX/MEM and MEM/WB bypass to EX; 0 = no bypass, interlock stalls on every RAW hazard.
- CNT_W, 32, width of instret counter.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  synchronous active-low reset.
- imem_addr  out  PC_W  fetch address (= PC, combinational).
- imem_data  in  32  instruction at imem_addr, same cycle.
- dmem_addr  out  DA_W  MEM-stage address.
- dmem_wdata  out  XLEN  store data.
- dmem_we  out  1  store strobe, one cycle per valid SW.
- dmem_rdata  in  XLEN  load data for dmem_addr, same cycle.
- dbg_raddr  in  5  debug register index.
- dbg_rdata  out  XLEN  Reg[dbg_raddr], combinational; 0 for index 0.
- halted  out  1  sticky; set when HLT retires.
- instret  out  CNT_W  count of retired valid instructions, including HLT.

Behaviour:
- Opcodes [31:26]: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101, LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100, BNEQZ 001101, BEQZ 001110, HLT 111111. Any other opcode decodes as HLT.
- Fields: rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- Destination register: R-R writes rd; ADDI/SUBI/SLTI/LW write rt. SLT/SLTI compare unsigned and produce 0/1. MUL keeps the low XLEN bits. Arithmetic wraps modulo 2^XLEN.
- Stages IF/ID/EX/MEM/WB each carry a valid bit. Bubbles have valid=0 and cause no register write, store or count.
- R0 reads as 0 and writes to it are dropped. Register file is write-first: a WB write is visible to ID in the same cycle.
- Latency: an instruction fetched in cycle n writes back at the edge ending cycle n+4.
- Forwarding (FORWARD=1): the EX operand takes EX/MEM ALU result, else MEM/WB result, else the ID/EX latch. A match requires a valid producer that writes a register with matching nonzero dest.
- Load-use: LW in EX whose rt is a nonzero source of the instruction in ID → stall 1 cycle. PC and IF/ID hold; a bubble goes into EX.
- FORWARD=0: ID stalls while any valid instruction in EX/MEM carries a matching nonzero dest. WB is covered by write-first.
- SW store data is also forwarded (or stalled when FORWARD=0).
- Branch resolves in EX. Target = ID_EX_NPC + sext(imm), truncated to PC_W. BEQZ is taken if A==0; BNEQZ is taken if A!=0. A is the forwarded value.
- Taken branch: PC ← target; IF/ID and ID/EX are invalidated (2-cycle penalty). Not taken: no penalty.
- A branch flush has priority over a stall in the same cycle.
- HLT in ID (valid, not flushed that cycle) sets fetch_stop: PC freezes and IF/ID loads bubbles.
- When HLT is valid in WB: halted ← 1, instret increments, and all pipeline state freezes.
- A HLT on the wrong path of a taken branch is flushed and has no effect.
- PC wraps modulo 2^PC_W.
- Reset (any cycle, including mid-operation or after halt): PC=0; all valid bits=0; halted=0; instret=0; fetch_stop=0; dmem_we=0. Registers R1–R31 are cleared to 0.
- dmem_addr and dmem_wdata are 0 when MEM is invalid.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release → imem_addr=0, dmem_we=0, halted=0, instret=0.
- RAW chain: program is ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; SUB R4,R3,R1; HLT.
  - Required results: R3=30, R4=20, instret=5.
  - FORWARD=1: halted rises at cycle 9.
  - FORWARD=0: same register results, halted strictly later.
- Load-use: program is ADDI R1,R0,7; SW R1,100(R0); LW R4,100(R0); ADD R5,R4,R4; HLT.
  - Required results: dmem_we pulses once at addr 100 with wdata 7; R5=14; exactly one stall bubble.
- Branch taken: program is BEQZ R0,+2; ADDI R6,R0,1; ADDI R7,R0,1; ADDI R8,R0,5; HLT.
  - Required results: R6=R7=0, R8=5, instret=3.
  - Wrong-path HLT after a taken branch is ignored.
- Loop: factorial of 5 using MUL, SUBI and a BNEQZ back-branch (imm=-3) → result register=120, halted=1; instret matches the hand count.
- Mid-run reset: pulse rst_n=0 for 1 cycle during the loop → immediate restart from PC 0, registers cleared, instret=0, final result still 120.
